lpc_frame_buffer: RTL
=====================

# lpc_frame_buffer

Downstream stage of the LPC encoder. Snapshots each completed coefficient set (A0..A10, voiced, freq_count) on the encoder's vout strobe. Queues up to DEPTH frames in an internal buffer and exposes the oldest frame to the host through the same 16-bit address/read/write register bus the encoder uses. Provides fill-level status, overflow accounting and a level-sensitive interrupt.

## Interface
- DEPTH, 4: frame slots; power of two, 2..16.
- clk  in  1  system clock (50 MHz); every signal is synchronous to it.
- rst  in  1  synchronous, active-high reset.
- A0..A10  in  16 each, signed  encoder coefficients; valid when vout rises.
- voiced  in  1  voicing decision, valid with vout.
- freq_count  in  16  pitch count, valid with vout.
- vout  in  1  encoder output-valid; rising edge marks a new frame.
- address  in  16  register address.
- read  in  1  read strobe, one cycle.
- write  in  1  write strobe, one cycle.
- writedata  in  16  write data.
- readdata  out  16  registered read data.
- irq  out  1  CTRL.irq_en & !empty.

## Operation
- Register map:
  - 0x00 STATUS, read: [4:0] level, [8] empty, [9] full, [10] overflow (sticky).
  - 0x00 STATUS, write: bit0 pop head frame, bit1 clear overflow, bit2 flush.
  - 0x01 DROPS: 16-bit saturating dropped-frame count; any write clears it.
  - 0x02 CTRL, R/W: bit0 enable, bit1 irq_en.
  - 0x10..0x1C: head-frame words 0..12, read-only.
  - All other addresses read 0; writes to them are ignored.
- Frame layout:
  - Words 0..10 = A0..A10.
  - Word 11 = freq_count.
  - Word 12 = {voiced, 7'b0, seq[7:0]}.
- seq: 8-bit count of accepted frames; wraps 255 -> 0; cleared by reset only (not by flush).
- Storage: DEPTH x 16 word memory. Word address = {slot, word[3:0]}. wr_ptr and rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH. level ranges 0..DEPTH.
- Write FSM, states IDLE and COPY:
  - IDLE, vout rise detected, enable=1, level<DEPTH: snapshot all inputs into a holding register; go to COPY with word=0.
  - IDLE, vout rise detected, enable=1, level==DEPTH: frame dropped. DROPS += 1 (saturates at 0xFFFF), overflow := 1. Stay in IDLE.
  - IDLE, vout rise detected, enable=0: ignored, not counted.
  - COPY: write one word per cycle, words 0..12. On word 12: wr_ptr += 1, level += 1, seq += 1; return to IDLE.
  - A vout rise during COPY is dropped and counted as above.
- Pop: rd_ptr += 1, level -= 1. Pop when empty is ignored.
- Pop and COPY completion in the same cycle: both take effect, so level is unchanged.
- Flush: level, wr_ptr and rd_ptr := 0. An in-progress COPY is aborted; that frame is discarded and not counted as a drop. Flush wins over a simultaneous pop or completion.
- Reading head words while empty returns 0.

## Timing
- Reset values:
  - Outputs: readdata=0, irq=0.
  - State: level 0, pointers 0, seq 0, DROPS 0, overflow 0, CTRL 0, FSM IDLE.
  - Internal vout delay register = 0, so vout held high through reset release produces a rise on the first cycle.
- vout rise sampled at edge E0 (snapshot taken). Words are written at edges E1..E13. level increments at E13. The new frame is readable with a read issued at E14.
- Read latency: 1. Read asserted in the cycle before edge E makes readdata valid after E. readdata holds its value until the next read.
- Read and pop in the same cycle: read returns pre-pop data.
- Register writes take effect at the edge on which write is sampled.
- irq updates one cycle after level or CTRL changes.
- rst asserted mid-COPY: the partial frame is lost and everything returns to reset values on that edge.

## Test plan
- Reset, then CTRL=1, then one vout pulse with A0=100, A10=-5, freq_count=57, voiced=1:
  - 14 cycles later STATUS=0x0001.
  - Reads of 0x10 / 0x1A / 0x1B / 0x1C return 100 / 0xFFFB / 57 / 0x8000.
- With DEPTH=4, push 5 frames without popping:
  - STATUS level=4, full=1, overflow=1; DROPS=1.
  - Head frame word 12 has seq=0.
  - Write STATUS bit1 clears overflow; DROPS stays 1.
- Pop while empty: level stays 0, no pointer movement, head reads 0. Pop with one frame: empty=1.
- Pop on the exact cycle COPY completes, with level=2: level remains 2; head advances to the next seq.
- vout rise 5 cycles into a COPY: DROPS increments; the original frame is stored intact. Flush mid-COPY: level=0, DROPS unchanged.
- 256 accepted frames with pops in between: seq wraps 255 -> 0. CTRL=3 with a frame queued: irq=1; pop to empty: irq=0 next cycle.

Source files
------------

// File: rtl/lpc_frame_buffer_if.sv
// Host register bus shared with the LPC encoder: 16-bit address, one-cycle
// read/write strobes, and registered read data.
interface lpc_frame_buffer_if;
  logic [15:0] address;
  logic        read;
  logic        write;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (output address, read, write, writedata, input readdata);
  modport slave  (input address, read, write, writedata, output readdata);
endinterface

// File: rtl/lpc_frame_buffer.sv
// Frame queue behind the LPC encoder: snapshots each coefficient set on a vout
// rise, copies it into a DEPTH-slot word memory and exposes the oldest frame.
module lpc_frame_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [15:0]  A0,
  input  logic signed [15:0]  A1,
  input  logic signed [15:0]  A2,
  input  logic signed [15:0]  A3,
  input  logic signed [15:0]  A4,
  input  logic signed [15:0]  A5,
  input  logic signed [15:0]  A6,
  input  logic signed [15:0]  A7,
  input  logic signed [15:0]  A8,
  input  logic signed [15:0]  A9,
  input  logic signed [15:0]  A10,
  input  logic                voiced,
  input  logic [15:0]         freq_count,
  input  logic                vout,
  lpc_frame_buffer_if.slave   bus,
  output logic                irq
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = PW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
  localparam logic [3:0]    LAST_WORD  = 4'd12;

  typedef enum logic {S_IDLE, S_COPY} state_t;

  state_t          r_state, w_state_nxt;
  logic [3:0]      r_word;
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]   r_level;
  logic [7:0]      r_seq;
  logic [15:0]     r_drops;
  logic            r_ovf;
  logic [1:0]      r_ctrl;
  logic            r_vout_d;
  logic            r_irq;
  logic [15:0]     r_readdata;
  logic [15:0]     r_hold [13];
  logic [15:0]     r_mem  [DEPTH*16];

  logic            w_vout_rise, w_empty, w_full;
  logic            w_wr_status, w_flush, w_pop, w_clr_ovf;
  logic            w_accept, w_drop, w_complete, w_mem_we;
  logic [15:0]     w_hold_word, w_rd_data, w_status;
  logic            w_unused;

  assign w_vout_rise = vout & ~r_vout_d;
  assign w_empty     = (r_level == '0);
  assign w_full      = (r_level == FULL_LEVEL);
  assign w_wr_status = bus.write && (bus.address == 16'h0000);
  assign w_flush     = w_wr_status & bus.writedata[2];
  assign w_clr_ovf   = w_wr_status & bus.writedata[1];
  assign w_pop       = w_wr_status & bus.writedata[0] & ~w_empty & ~w_flush;
  assign w_unused    = &{1'b0, bus.writedata[15:3]};

  assign irq          = r_irq;
  assign bus.readdata = r_readdata;

  // Flush overrides every FSM action, including a completion on this edge.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_drop      = 1'b0;
    w_complete  = 1'b0;
    w_mem_we    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_vout_rise && r_ctrl[0]) begin
          if (!w_full) begin
            w_accept    = 1'b1;
            w_state_nxt = S_COPY;
          end else begin
            w_drop = 1'b1;
          end
        end
      end
      S_COPY: begin
        w_mem_we = 1'b1;
        if (w_vout_rise && r_ctrl[0]) w_drop = 1'b1;
        if (r_word == LAST_WORD) begin
          w_complete  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_flush) begin
      w_state_nxt = S_IDLE;
      w_accept    = 1'b0;
      w_complete  = 1'b0;
      w_mem_we    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_word   <= '0;
      r_vout_d <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_vout_d <= vout;
      if (w_accept)                r_word <= '0;
      else if (r_state == S_COPY)  r_word <= r_word + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_hold[0]  <= A0;
      r_hold[1]  <= A1;
      r_hold[2]  <= A2;
      r_hold[3]  <= A3;
      r_hold[4]  <= A4;
      r_hold[5]  <= A5;
      r_hold[6]  <= A6;
      r_hold[7]  <= A7;
      r_hold[8]  <= A8;
      r_hold[9]  <= A9;
      r_hold[10] <= A10;
      r_hold[11] <= freq_count;
      r_hold[12] <= {voiced, 7'b0, r_seq};
    end
  end

  always_comb begin
    w_hold_word = '0;
    if (r_word <= LAST_WORD) w_hold_word = r_hold[r_word];
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[{r_wr_ptr, r_word}] <= w_hold_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_seq    <= '0;
    end else begin
      if (w_complete) r_seq <= r_seq + 8'd1;
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
      end else begin
        if (w_complete) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)      r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_complete, w_pop})
          2'b10:   r_level <= r_level + 1'b1;
          2'b01:   r_level <= r_level - 1'b1;
          default: r_level <= r_level;
        endcase
      end
    end
  end

  // A drop on the same edge as a clear still leaves the event recorded.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drops <= '0;
      r_ovf   <= 1'b0;
      r_ctrl  <= '0;
      r_irq   <= 1'b0;
    end else begin
      if (w_drop && r_drops != 16'hFFFF)              r_drops <= r_drops + 16'd1;
      else if (bus.write && bus.address == 16'h0001)  r_drops <= '0;
      if (w_drop)          r_ovf <= 1'b1;
      else if (w_clr_ovf)  r_ovf <= 1'b0;
      if (bus.write && bus.address == 16'h0002) r_ctrl <= bus.writedata[1:0];
      r_irq <= r_ctrl[1] & ~w_empty;
    end
  end

  always_comb begin
    w_status           = '0;
    w_status[LW-1:0]   = r_level;
    w_status[8]        = w_empty;
    w_status[9]        = w_full;
    w_status[10]       = r_ovf;
    w_rd_data          = '0;
    case (bus.address)
      16'h0000: w_rd_data = w_status;
      16'h0001: w_rd_data = r_drops;
      16'h0002: w_rd_data = {14'b0, r_ctrl};
      default: begin
        if (bus.address[15:4] == 12'h001 && bus.address[3:0] <= LAST_WORD && !w_empty)
          w_rd_data = r_mem[{r_rd_ptr, bus.address[3:0]}];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)           r_readdata <= '0;
    else if (bus.read) r_readdata <= w_rd_data;
  end
endmodule
